// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: shared size/state encodings and RAM geometry for the load/store unit
package dmem_lsu_pkg;
    localparam int RAM_AW = 12;
    localparam int RAM_DEPTH_DEF = 4096;
    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILL = 2'b11} size_e;
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_RESP} state_e;
    function automatic logic misaligned(input size_e size, input logic [1:0] off);
        return size == SZ_ILL || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
    endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: load lane extraction/extension and sub-word store merge
module lsu_lane_align import dmem_lsu_pkg::*; (
    input  logic [31:0] rd_word_i,
    input  logic [31:0] base_word_i,
    input  logic [31:0] wdata_i,
    input  size_e       size_i,
    input  logic        uns_i,
    input  logic [1:0]  off_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o
);
    logic [4:0]  sh;
    logic [31:0] lane;
    logic [31:0] mask;
    // shift the addressed lane down for loads, and up into a masked word for stores
    always_comb begin
        sh = {off_i, 3'b000};
        lane = rd_word_i >> sh;
        load_data_o = size_i == SZ_BYTE ? {{24{~uns_i & lane[7]}}, lane[7:0]} :
                       size_i == SZ_HALF ? {{16{~uns_i & lane[15]}}, lane[15:0]} : rd_word_i;
        mask = size_i == SZ_BYTE ? 32'h0000_00ff << sh :
               size_i == SZ_HALF ? 32'h0000_ffff << sh : 32'hffff_ffff;
        merge_data_o = (base_word_i & ~mask) | ((wdata_i << sh) & mask);
    end
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: single-outstanding load/store unit in front of a combinational-read data RAM
module dmem_lsu import dmem_lsu_pkg::*; #(
    parameter int RAM_DEPTH = RAM_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_wr_en,
    output logic [31:0]       ram_wr_data,
    input  logic [31:0]       ram_rd_data
);
    state_e            state_q;
    logic              we_q;
    size_e             size_q;
    logic              uns_q;
    logic [RAM_AW+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [31:0]       resp_rdata_q;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;
    logic              req_err;
    logic              sub_store;

    assign req_err = misaligned(size_e'(req_size), req_addr[1:0]) || ({2'b00, req_addr[31:2]} >= 32'(RAM_DEPTH));
    assign sub_store = we_q && size_q != SZ_WORD;
    assign req_ready = state_q == S_IDLE;
    assign resp_valid = resp_valid_q;
    assign resp_err = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign ram_addr = addr_q[RAM_AW+1:2];
    assign ram_wr_en = (state_q == S_ACCESS && we_q && !sub_store) || state_q == S_WRITE;
    assign ram_wr_data = merge_data;

    lsu_lane_align u_align (
        .rd_word_i    (ram_rd_data),
        .base_word_i  (word_q),
        .wdata_i      (wdata_q),
        .size_i       (size_q),
        .uns_i        (uns_q),
        .off_i        (addr_q[1:0]),
        .load_data_o  (load_data),
        .merge_data_o (merge_data)
    );

    // request/response FSM; errors skip the RAM, sub-word stores read-modify-write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q <= 1'b0;
            size_q <= SZ_BYTE;
            uns_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            word_q <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (req_valid) begin
                    we_q <= req_we;
                    size_q <= size_e'(req_size);
                    uns_q <= req_unsigned;
                    addr_q <= req_addr[RAM_AW+1:0];
                    wdata_q <= req_wdata;
                    state_q <= req_err ? S_RESP : S_ACCESS;
                    resp_valid_q <= req_err;
                    resp_err_q <= req_err;
                    resp_rdata_q <= '0;
                end
                S_ACCESS: begin
                    state_q <= sub_store ? S_WRITE : S_RESP;
                    resp_valid_q <= !sub_store;
                    resp_rdata_q <= we_q ? '0 : load_data;
                    word_q <= ram_rd_data;
                end
                S_WRITE: begin
                    state_q <= S_RESP;
                    resp_valid_q <= 1'b1;
                end
                S_RESP: if (resp_ready) begin
                    state_q <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q <= 1'b0;
                    resp_rdata_q <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: randomized and directed checks of dmem_lsu against a transaction-level memory model
module tb_dmem_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [11:0] ram_addr;
    logic        ram_wr_en;
    logic [31:0] ram_wr_data;
    logic [31:0] ram_rd_data;

    bit [31:0]   mem [4096];
    bit [31:0]   ref_mem [4096];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] exp_rdata = '0;
    logic        exp_err = 1'b0;

    dmem_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .ram_addr     (ram_addr),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_data  (ram_wr_data),
        .ram_rd_data  (ram_rd_data)
    );

    always #5 clk = ~clk;

    assign ram_rd_data = mem[ram_addr];

    // data RAM: combinational read, write on the clock edge
    always @(posedge clk) if (ram_wr_en) mem[ram_addr] <= ram_wr_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // transaction-level reference: decides error, data, latency and updates the model memory
    task automatic model(input bit we, input bit [1:0] sz, input bit un, input bit [31:0] a, input bit [31:0] wd,
                         output bit err, output bit [31:0] rd, output int lat, output int nwr);
        bit [31:0] w;
        bit [31:0] v;
        int nb;
        int off;
        err = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || a[31:2] >= 30'd4096;
        rd = 0;
        lat = 1;
        nwr = 0;
        if (!err) begin
            w = ref_mem[a[13:2]];
            nb = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
            off = int'(a[1:0]);
            if (!we) begin
                v = w >> (8 * off);
                if (nb == 1) v = un ? (v & 32'hff) : {{24{v[7]}}, v[7:0]};
                if (nb == 2) v = un ? (v & 32'hffff) : {{16{v[15]}}, v[15:0]};
                rd = v;
                lat = 2;
            end else begin
                for (int b = 0; b < nb; b++) w[8 * (off + b) +: 8] = wd[8 * b +: 8];
                ref_mem[a[13:2]] = w;
                lat = nb == 4 ? 2 : 3;
                nwr = 1;
            end
        end
    endtask

    // every cycle a response is shown it must match the model and block new requests
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            chk("mon_rdata", resp_rdata, exp_rdata);
            chk("mon_err", 32'(resp_err), 32'(exp_err));
            chk("mon_req_ready", 32'(req_ready), 0);
        end
    end

    task automatic txn(input bit we, input bit [1:0] sz, input bit un, input bit [31:0] a, input bit [31:0] wd,
                       input int hold, output logic [31:0] got);
        bit e_err;
        bit [31:0] e_rd;
        int e_lat, e_wr, lat, wrc, wat;
        model(we, sz, un, a, wd, e_err, e_rd, e_lat, e_wr);
        exp_rdata = e_rd;
        exp_err = e_err;
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_we = we;
        req_size = sz;
        req_unsigned = un;
        req_addr = a;
        req_wdata = wd;
        lat = 0;
        wrc = 0;
        wat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(negedge clk);
            if (i == 1) req_valid = 1'b0;
            if (ram_wr_en) begin
                wrc++;
                wat = i;
                chk("wr_addr", 32'(ram_addr), 32'(a[13:2]));
            end
            if (resp_valid) lat = i;
        end
        chk("latency", lat, e_lat);
        chk("wr_count", wrc, e_wr);
        if (e_wr != 0) chk("wr_cycle", wat, e_lat - 1);
        chk("rdata", resp_rdata, e_rd);
        chk("err", 32'(resp_err), 32'(e_err));
        got = resp_rdata;
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            req_we = 1'b1;
            req_size = 2'b10;
            req_addr = 32'h0;
            req_wdata = 32'hBAD0BAD0;
            @(negedge clk);
            chk("hold_no_wr", 32'(ram_wr_en), 0);
            chk("hold_valid", 32'(resp_valid), 1);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid = 1'b0;
        chk("exit_valid", 32'(resp_valid), 0);
        chk("exit_ready", 32'(req_ready), 1);
        chk("exit_no_wr", 32'(ram_wr_en), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] got;
        bit [31:0] ra;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_err", 32'(resp_err), 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_wr_en", 32'(ram_wr_en), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_wr_data", ram_wr_data, 0);
        rst = 1'b0;
        txn(1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 0, got);
        txn(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 0, got);
        chk("lit_load_word", got, 32'hDEADBEEF);
        txn(1'b1, 2'd0, 1'b0, 32'h012, 32'h0000005A, 0, got);
        chk("lit_mem4", mem[4], 32'hDE5ABEEF);
        txn(1'b0, 2'd0, 1'b0, 32'h013, 32'h0, 0, got);
        chk("lit_lb", got, 32'hFFFFFFDE);
        txn(1'b0, 2'd0, 1'b1, 32'h013, 32'h0, 0, got);
        chk("lit_lbu", got, 32'h000000DE);
        txn(1'b0, 2'd1, 1'b0, 32'h012, 32'h0, 0, got);
        chk("lit_lh", got, 32'hFFFFDE5A);
        txn(1'b0, 2'd2, 1'b0, 32'h006, 32'h0, 0, got);
        chk("lit_err_lw", got, 32'h0);
        txn(1'b1, 2'd1, 1'b0, 32'h001, 32'h1234, 0, got);
        chk("lit_err_sh", got, 32'h0);
        txn(1'b0, 2'd3, 1'b0, 32'h000, 32'h0, 0, got);
        chk("lit_err_size", got, 32'h0);
        txn(1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 0, got);
        chk("lit_err_range", got, 32'h0);
        chk("lit_mem4_kept", mem[4], 32'hDE5ABEEF);
        txn(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 5, got);
        chk("lit_hold_word", got, 32'hDE5ABEEF);
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_size = 2'd0;
        req_unsigned = 1'b0;
        req_addr = 32'h012;
        req_wdata = 32'h77;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_write", 32'(ram_wr_en), 1);
        rst = 1'b1;
        #1;
        chk("abort_wr_en", 32'(ram_wr_en), 0);
        chk("abort_req_ready", 32'(req_ready), 1);
        chk("abort_resp_valid", 32'(resp_valid), 0);
        chk("abort_ram_addr", 32'(ram_addr), 0);
        chk("abort_wr_data", ram_wr_data, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_mem4", mem[4], 32'hDE5ABEEF);
        chk("abort_post_valid", 32'(resp_valid), 0);
        chk("abort_post_ready", 32'(req_ready), 1);
        for (int n = 0; n < 300; n++) begin
            ra = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
            txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra,
                32'($urandom), $urandom_range(0, 2), got);
        end
        for (int w = 0; w < 64; w++) chk($sformatf("mem_word_%0d", w), mem[w], ref_mem[w]);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
